// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared UART definitions used by the receiver (and its transmitter partner).
//   - receiver FSM state encoding (IDLE, START, DATA, STOP)
//   - UART_MIN_BAUD_DIV : smallest legal clk-cycles-per-bit value
//   - half_bit_term()   : terminal count for the half-bit start-bit check
// -----------------------------------------------------------------------------
package uart_rx_pkg;

    localparam int UART_MIN_BAUD_DIV = 4;

    typedef logic [1:0] rx_state_t;

    localparam rx_state_t ST_IDLE  = 2'd0;
    localparam rx_state_t ST_START = 2'd1;
    localparam rx_state_t ST_DATA  = 2'd2;
    localparam rx_state_t ST_STOP  = 2'd3;

    // The counter runs 0..term, so a half-bit wait of div/2 cycles ends at div/2-1.
    function automatic logic [15:0] half_bit_term(input logic [15:0] div);
        return (div >> 1) - 16'd1;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if
// Bundles the receiver's control, serial and read-side signals.
//   slave  : the receiver (inputs baud_div_i, rx_en_i, rx_bit_i, rx_re_i;
//            outputs dout_o, full_o, empty_o, frame_err_o, overrun_o, busy_o,
//            state_o)
//   master : the driving side (bus logic or testbench), directions reversed.
// Read handshake: dout_o is the FIFO head and is valid whenever empty_o=0;
// a cycle with rx_re_i=1 and empty_o=0 consumes that word at the clock edge.
// rx_re_i while empty_o=1 is ignored.
// -----------------------------------------------------------------------------
interface uart_rx_if
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) ();

    logic [15:0]           baud_div_i;
    logic                  rx_en_i;
    logic                  rx_bit_i;
    logic                  rx_re_i;
    logic [DATA_WIDTH-1:0] dout_o;
    logic                  full_o;
    logic                  empty_o;
    logic                  frame_err_o;
    logic                  overrun_o;
    logic                  busy_o;
    rx_state_t             state_o;

    modport slave (
        input  baud_div_i, rx_en_i, rx_bit_i, rx_re_i,
        output dout_o, full_o, empty_o, frame_err_o, overrun_o, busy_o, state_o
    );

    modport master (
        output baud_div_i, rx_en_i, rx_bit_i, rx_re_i,
        input  dout_o, full_o, empty_o, frame_err_o, overrun_o, busy_o, state_o
    );

endinterface

// File: rtl/uart_rx_wbit_fifo.sv
// -----------------------------------------------------------------------------
// wbit_fifo
// Synchronous first-word-fall-through FIFO, DATA_WIDTH x FIFO_DEPTH.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   wr_en_i       : write wr_data_i (ignored when full_o)
//   rd_en_i       : pop the head (ignored when empty_o)
//   rd_data_o     : head word, 0 while empty
//   full_o/empty_o: occupancy flags
// Simultaneous read and write when neither full nor empty keeps the count.
// -----------------------------------------------------------------------------
module wbit_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  do_wr;
    logic                  do_rd;

    assign full_o  = (count == FULL_CNT);
    assign empty_o = (count == '0);
    assign do_wr   = wr_en_i && !full_o;
    assign do_rd   = rd_en_i && !empty_o;

    // Head is forced to 0 when empty so the read port has a defined reset value
    // even though the storage array itself is not reset.
    assign rd_data_o = empty_o ? '0 : mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
            end
            if (do_wr && !do_rd) begin
                count <= count + 1'b1;
            end else if (do_rd && !do_wr) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver (LSB first, 1 start bit, 1 stop bit, no parity) feeding a
// first-word-fall-through receive FIFO.
//   clk_i : clock, all logic on posedge
//   rst_i : asynchronous active-high reset
//   bus   : uart_rx_if slave modport
//           baud_div_i  clk cycles per bit (>= 4), latched at start-bit detect
//           rx_en_i     enable; low aborts any frame in progress
//           rx_bit_i    asynchronous serial line, idle high
//           rx_re_i     pop FIFO head
//           dout_o      FIFO head, valid while empty_o=0
//           full_o / empty_o  FIFO flags
//           frame_err_o 1-cycle pulse: stop bit sampled low
//           overrun_o   1-cycle pulse: good byte dropped, FIFO full
//           busy_o      receiver not idle
//           state_o     current FSM state (debug)
// The line is sampled once per bit near the bit centre: half a bit after the
// start edge, then every full bit period.
// -----------------------------------------------------------------------------
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 32
) (
    input  logic     clk_i,
    input  logic     rst_i,
    uart_rx_if.slave bus
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    rx_state_t             state;
    logic                  rx_m;
    logic                  rx_s;
    logic                  rx_q;
    logic [15:0]           div_q;
    logic [15:0]           cnt;
    logic [15:0]           term;
    logic                  tick;
    logic [BW-1:0]         bit_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  frame_err;
    logic                  overrun;
    logic                  wr_en;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_dout;

    // Terminal count: half a bit while checking the start bit, a full bit after.
    always_comb begin
        term = div_q - 16'd1;
        if (state == ST_START) begin
            term = half_bit_term(div_q);
        end
    end

    assign tick = (cnt == term);

    // A good stop bit writes the byte on the same edge that samples it, so
    // empty_o drops in the following cycle. A full FIFO drops the byte even if
    // a pop happens in that cycle, since full_o is still high.
    assign wr_en = bus.rx_en_i && (state == ST_STOP) && tick && rx_s && !fifo_full;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_m      <= 1'b1;
            rx_s      <= 1'b1;
            rx_q      <= 1'b1;
            state     <= ST_IDLE;
            div_q     <= '0;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_m      <= bus.rx_bit_i;
            rx_s      <= rx_m;
            rx_q      <= rx_s;
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            if (!bus.rx_en_i) begin
                state   <= ST_IDLE;
                cnt     <= '0;
                bit_idx <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        // Edge (not level) detect: a line stuck low starts one frame only.
                        if (rx_q && !rx_s) begin
                            state <= ST_START;
                            div_q <= bus.baud_div_i;
                            cnt   <= '0;
                        end
                    end
                    ST_START: begin
                        if (tick) begin
                            cnt <= '0;
                            if (!rx_s) begin
                                state   <= ST_DATA;
                                bit_idx <= '0;
                            end else begin
                                // Line went back high before mid start bit: glitch.
                                state <= ST_IDLE;
                            end
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    ST_DATA: begin
                        if (tick) begin
                            cnt   <= '0;
                            // Shift in at the MSB so the first (LSB) bit ends at bit 0.
                            shreg <= {rx_s, shreg[DATA_WIDTH-1:1]};
                            if (bit_idx == LAST_BIT) begin
                                state <= ST_STOP;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    ST_STOP: begin
                        if (tick) begin
                            cnt   <= '0;
                            state <= ST_IDLE;
                            if (!rx_s) begin
                                frame_err <= 1'b1;
                            end else if (fifo_full) begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    wbit_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (wr_en),
        .wr_data_i (shreg),
        .rd_en_i   (bus.rx_re_i),
        .rd_data_o (fifo_dout),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign bus.dout_o      = fifo_dout;
    assign bus.full_o      = fifo_full;
    assign bus.empty_o     = fifo_empty;
    assign bus.frame_err_o = frame_err;
    assign bus.overrun_o   = overrun;
    assign bus.busy_o      = (state != ST_IDLE);
    assign bus.state_o     = state;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Drives 8N1 frames onto rx_bit_i and checks received bytes through an
// expected-byte queue popped by an independent monitor, plus flag counts,
// latency and reset behaviour.
// -----------------------------------------------------------------------------
module tb_uart_rx;
    import uart_rx_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_rx_if #(.DATA_WIDTH(8)) bus ();

    uart_rx #(
        .DATA_WIDTH (8),
        .FIFO_DEPTH (32)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    bit         pop_en   = 1'b1;
    int         fe_seen  = 0;
    int         ov_seen  = 0;
    int         fe_exp   = 0;
    int         ov_exp   = 0;
    bit         saw_busy = 1'b0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, req, req, $time);
        end
    endtask

    // ---------------- monitor: pop and compare ----------------
    initial begin
        bus.rx_re_i = 1'b0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                bus.rx_re_i = 1'b0;
            end else if (pop_en && !bus.empty_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", int'(bus.dout_o), -1);
                end else begin
                    check("rx_byte", int'(bus.dout_o), int'(exp_q.pop_front()));
                end
                bus.rx_re_i = 1'b1;
            end else begin
                bus.rx_re_i = 1'b0;
            end
        end
    end

    // Flag pulses are counted per high cycle, so a stretched pulse over-counts.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                if (bus.frame_err_o) fe_seen++;
                if (bus.overrun_o)   ov_seen++;
                if (bus.busy_o)      saw_busy = 1'b1;
            end
        end
    end

    // ---------------- driver ----------------
    // Sends one frame of div cycles per bit followed by an idle-high gap.
    // lat = cycles from start-bit launch until empty_o is first seen low
    // (-1 if it never falls or the FIFO was not empty at launch).
    // abort_bit >= 0 drops rx_en_i in the middle of that data bit.
    task automatic send_frame(input logic [7:0] data, input int div, input bit stop_val,
                              input int abort_bit, output int lat);
        logic [9:0] frame;
        int         gap;
        int         total;
        int         abort_k;
        bit         was_empty;
        frame     = {stop_val, data, 1'b0};
        gap       = div + 4 + int'($urandom_range(0, div));
        total     = 10 * div + gap;
        abort_k   = (abort_bit >= 0) ? (abort_bit + 1) * div + div / 2 : -100;
        lat       = -1;
        bus.baud_div_i = 16'(div);
        @(posedge clk); #1;
        was_empty = bus.empty_o;
        for (int k = 0; k < total; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            bus.rx_bit_i = (k < 10 * div) ? frame[k / div] : 1'b1;
            // A new divisor mid-frame must not disturb the frame in flight.
            if (k == 2 * div) bus.baud_div_i = 16'($urandom_range(4, 40));
            if (k == abort_k) bus.rx_en_i = 1'b0;
            if (k == abort_k + 2) check("abort_busy", int'(bus.busy_o), 0);
            if (was_empty && lat < 0 && !bus.empty_o) lat = k;
        end
        bus.rx_en_i = 1'b1;
    endtask

    // Reference timing: the start edge is seen 3 cycles late (2 sync flops plus
    // edge detect); the stop bit is sampled half a bit into bit 9; the byte is
    // visible the cycle after that sample.
    function automatic int exp_latency(input int div);
        return 9 * div + div / 2 + 3;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int div;
        logic [7:0] d;

        rst            = 1'b1;
        bus.baud_div_i = 16'd16;
        bus.rx_en_i    = 1'b1;
        bus.rx_bit_i   = 1'b1;
        #23;
        // Reset values
        check("rst_empty", int'(bus.empty_o), 1);
        check("rst_full",  int'(bus.full_o), 0);
        check("rst_busy",  int'(bus.busy_o), 0);
        check("rst_dout",  int'(bus.dout_o), 0);
        check("rst_flags", int'({bus.frame_err_o, bus.overrun_o}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(5);

        // 0xA5 at div 16
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 16, 1'b1, -1, lat);
        check("a5_latency", lat, exp_latency(16));
        check("a5_flags", fe_seen + ov_seen, 0);

        // 4-cycle glitch on the idle line
        bus.baud_div_i = 16'd16;
        saw_busy = 1'b0;
        @(posedge clk); #1;
        bus.rx_bit_i = 1'b0;
        idle(4);
        bus.rx_bit_i = 1'b1;
        idle(40);
        check("glitch_saw_start", int'(saw_busy), 1);
        check("glitch_idle", int'(bus.busy_o), 0);
        check("glitch_empty", int'(bus.empty_o), 1);
        check("glitch_flags", fe_seen + ov_seen, 0);

        // Framing error, then the same byte with a good stop bit
        fe_exp++;
        send_frame(8'h3C, 16, 1'b0, -1, lat);
        check("fe_no_push", lat, -1);
        check("fe_pulses", fe_seen, fe_exp);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 16, 1'b1, -1, lat);
        check("3c_latency", lat, exp_latency(16));

        // Fill to full without popping, then one more for overrun
        pop_en = 1'b0;
        idle(4);
        for (int i = 0; i < 33; i++) begin
            if (i < 32) exp_q.push_back(8'(i));
            else        ov_exp++;
            send_frame(8'(i), 8, 1'b1, -1, lat);
            if (i == 30) check("full_before_32", int'(bus.full_o), 0);
            if (i == 31) check("full_after_32", int'(bus.full_o), 1);
        end
        check("ov_pulses", ov_seen, ov_exp);
        check("ov_still_full", int'(bus.full_o), 1);
        pop_en = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        idle(3);
        check("fill_drained", exp_q.size(), 0);
        check("fill_empty", int'(bus.empty_o), 1);

        // Drop rx_en_i during bit 3 of 0xFF, then 0x5A
        send_frame(8'hFF, 16, 1'b1, 3, lat);
        check("abort_no_push", lat, -1);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 16, 1'b1, -1, lat);
        check("5a_latency", lat, exp_latency(16));

        // Randomized frames with random divisors
        for (int i = 0; i < 12; i++) begin
            d   = 8'($urandom_range(0, 255));
            div = int'($urandom_range(UART_MIN_BAUD_DIV, 20));
            exp_q.push_back(d);
            send_frame(d, div, 1'b1, -1, lat);
            check("rand_latency", lat, exp_latency(div));
        end

        // Reset mid-frame with a byte still queued
        pop_en = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 8, 1'b1, -1, lat);
        bus.baud_div_i = 16'd8;
        @(posedge clk); #1;
        bus.rx_bit_i = 1'b0;
        idle(12);
        bus.rx_bit_i = 1'b1;
        idle(7);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_empty", int'(bus.empty_o), 1);
        check("mid_rst_full", int'(bus.full_o), 0);
        check("mid_rst_dout", int'(bus.dout_o), 0);
        check("mid_rst_busy", int'(bus.busy_o), 0);
        check("mid_rst_flags", int'({bus.frame_err_o, bus.overrun_o}), 0);
        exp_q.delete();
        idle(3);
        rst = 1'b0;
        idle(20);
        pop_en = 1'b1;
        exp_q.push_back(8'h81);
        send_frame(8'h81, 4, 1'b1, -1, lat);
        check("81_latency", lat, exp_latency(4));

        // Final drain and flag totals
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        idle(3);
        check("final_drain", exp_q.size(), 0);
        check("final_fe", fe_seen, fe_exp);
        check("final_ov", ov_seen, ov_exp);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
